// File: rtl/controle_venda_pkg.sv
// Shared definitions for the vending controller and the coin accumulator:
// FSM state encoding, credit units (25-cent steps) and default prices.
package controle_venda_pkg;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      VERIFICA = 3'd1,
      LIBERA   = 3'd2,
      AVISO    = 3'd3,
      DEVOLVE  = 3'd4
   } estado_t;

   // Credit is counted in 25-cent units; the accumulator never exceeds 8 (R$2.00).
   localparam logic [3:0] CREDITO_MIN = 4'd0;
   localparam logic [3:0] UNIDADE_25C = 4'd1;
   localparam logic [3:0] VALOR_50C   = 4'd2;
   localparam logic [3:0] VALOR_1REAL = 4'd4;
   localparam logic [3:0] CREDITO_MAX = 4'd8;

   // Default product prices, in 25-cent units.
   localparam int PRECO_0_PADRAO = 3;
   localparam int PRECO_1_PADRAO = 4;
   localparam int PRECO_2_PADRAO = 5;
   localparam int PRECO_3_PADRAO = 6;

   // Saturate a credit value to the accumulator's legal range.
   function automatic logic [3:0] limita_credito(input logic [3:0] valor);
      if (valor > CREDITO_MAX) begin
         return CREDITO_MAX;
      end else begin
         return valor;
      end
   endfunction

endpackage

// File: rtl/controle_venda_contador.sv
// Generic timer: clear, load or count up; 'fim' flags the edge at which the
// count reaches 'limite'. Used for both the warning hold and the idle refund.
module contador_inatividade #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] valor_carga,
   input  logic         conta,
   input  logic [W-1:0] limite,
   output logic         fim
);

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_mais_um_s;

   assign cnt_mais_um_s = cnt_r + {{(W-1){1'b0}}, 1'b1};

   // Counter register: clear has priority over load, load over counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {W{1'b0}};
      end else if (clear) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= valor_carga;
      end else if (conta) begin
         cnt_r <= cnt_mais_um_s;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Terminal flag: true when the value written at this edge reaches the limit.
   always_comb begin
      fim = 1'b0;
      if (clear) begin
         fim = 1'b0;
      end else if (load) begin
         fim = (valor_carga >= limite);
      end else if (conta) begin
         fim = (cnt_mais_um_s >= limite);
      end else begin
         fim = 1'b0;
      end
   end

endmodule

// File: rtl/controle_venda.sv
// Vending machine sale controller: checks credit against the selected
// product's price, dispenses with change, warns on short credit and refunds
// on request or after a period of inactivity. All outputs are registered
// copies of the next state's decode, so they behave as Moore outputs.
module controle_venda
   import controle_venda_pkg::*;
#(
   parameter int PRECO_0   = PRECO_0_PADRAO,
   parameter int PRECO_1   = PRECO_1_PADRAO,
   parameter int PRECO_2   = PRECO_2_PADRAO,
   parameter int PRECO_3   = PRECO_3_PADRAO,
   parameter int T_AVISO   = 4,
   parameter int T_INATIVO = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] total,
   input  logic [1:0] produto,
   input  logic       confirma,
   input  logic       cancela,
   output logic       libera,
   output logic [1:0] produto_out,
   output logic [3:0] troco,
   output logic       troco_valido,
   output logic       limpa_acumulador,
   output logic       saldo_insuf,
   output logic       ocupado
);

   localparam int         W_CNT       = 8;
   localparam logic [7:0] LIM_AVISO   = 8'(T_AVISO);
   localparam logic [7:0] LIM_INATIVO = 8'(T_INATIVO);
   localparam logic [3:0] P0          = 4'(PRECO_0);
   localparam logic [3:0] P1          = 4'(PRECO_1);
   localparam logic [3:0] P2          = 4'(PRECO_2);
   localparam logic [3:0] P3          = 4'(PRECO_3);

   estado_t    state_r, state_next_s;
   logic [1:0] sel_r, sel_next_s;
   logic [3:0] cred_r, cred_next_s;
   logic [3:0] total_ant_r;
   logic [3:0] total_c_s;
   logic       ocioso_s, mudou_s, fim_inat_s, fim_aviso_s;

   logic       libera_next_s, troco_valido_next_s, limpa_next_s;
   logic       saldo_next_s, ocupado_next_s;
   logic [1:0] produto_out_next_s;
   logic [3:0] troco_next_s;

   function automatic logic [3:0] preco(input logic [1:0] codigo);
      case (codigo)
         2'b00:   preco = P0;
         2'b01:   preco = P1;
         2'b10:   preco = P2;
         2'b11:   preco = P3;
         default: preco = P3;
      endcase
   endfunction

   assign total_c_s = limita_credito(total);
   assign mudou_s   = (total_c_s != total_ant_r);
   assign ocioso_s  = (state_r == OCIOSO) && (total_c_s != CREDITO_MIN) &&
                      !confirma && !cancela;

   // Idle refund timer; a credit change restarts it with the current cycle as the first.
   contador_inatividade #(.W(W_CNT)) u_inatividade (
      .clk         (clk),
      .reset       (reset),
      .clear       (!ocioso_s),
      .load        (ocioso_s && mudou_s),
      .valor_carga (8'd1),
      .conta       (ocioso_s && !mudou_s),
      .limite      (LIM_INATIVO),
      .fim         (fim_inat_s)
   );

   // Warning hold timer, running only while in AVISO.
   contador_inatividade #(.W(W_CNT)) u_aviso (
      .clk         (clk),
      .reset       (reset),
      .clear       (state_r != AVISO),
      .load        (1'b0),
      .valor_carga (8'd0),
      .conta       (state_r == AVISO),
      .limite      (LIM_AVISO),
      .fim         (fim_aviso_s)
   );

   // Next-state logic, product latch and credit capture.
   always_comb begin
      state_next_s = state_r;
      sel_next_s   = sel_r;
      cred_next_s  = cred_r;
      case (state_r)
         OCIOSO: begin
            if (cancela && (total_c_s != CREDITO_MIN)) begin
               state_next_s = DEVOLVE;
               cred_next_s  = total_c_s;
            end else if (confirma) begin
               state_next_s = VERIFICA;
               sel_next_s   = produto;
            end else if (fim_inat_s) begin
               state_next_s = DEVOLVE;
               cred_next_s  = total_c_s;
            end else begin
               state_next_s = OCIOSO;
            end
         end
         VERIFICA: begin
            cred_next_s = total_c_s;
            if (total_c_s >= preco(sel_r)) begin
               state_next_s = LIBERA;
            end else begin
               state_next_s = AVISO;
            end
         end
         LIBERA: begin
            state_next_s = OCIOSO;
         end
         AVISO: begin
            if (cancela) begin
               state_next_s = DEVOLVE;
               cred_next_s  = total_c_s;
            end else if (fim_aviso_s) begin
               state_next_s = OCIOSO;
            end else begin
               state_next_s = AVISO;
            end
         end
         DEVOLVE: begin
            state_next_s = OCIOSO;
         end
         default: begin
            state_next_s = OCIOSO;
         end
      endcase
   end

   // Output decode of the state being entered, registered below.
   always_comb begin
      libera_next_s       = 1'b0;
      produto_out_next_s  = 2'd0;
      troco_next_s        = 4'd0;
      troco_valido_next_s = 1'b0;
      limpa_next_s        = 1'b0;
      saldo_next_s        = 1'b0;
      ocupado_next_s      = (state_next_s != OCIOSO);
      case (state_next_s)
         LIBERA: begin
            libera_next_s       = 1'b1;
            produto_out_next_s  = sel_next_s;
            troco_next_s        = cred_next_s - preco(sel_next_s);
            troco_valido_next_s = 1'b1;
            limpa_next_s        = 1'b1;
         end
         DEVOLVE: begin
            troco_next_s        = cred_next_s;
            troco_valido_next_s = 1'b1;
            limpa_next_s        = 1'b1;
         end
         AVISO: begin
            saldo_next_s = 1'b1;
         end
         default: begin
            saldo_next_s = 1'b0;
         end
      endcase
   end

   // State, latched selection/credit, previous total and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= OCIOSO;
         sel_r            <= 2'd0;
         cred_r           <= 4'd0;
         total_ant_r      <= 4'd0;
         libera           <= 1'b0;
         produto_out      <= 2'd0;
         troco            <= 4'd0;
         troco_valido     <= 1'b0;
         limpa_acumulador <= 1'b0;
         saldo_insuf      <= 1'b0;
         ocupado          <= 1'b0;
      end else begin
         state_r          <= state_next_s;
         sel_r            <= sel_next_s;
         cred_r           <= cred_next_s;
         total_ant_r      <= total_c_s;
         libera           <= libera_next_s;
         produto_out      <= produto_out_next_s;
         troco            <= troco_next_s;
         troco_valido     <= troco_valido_next_s;
         limpa_acumulador <= limpa_next_s;
         saldo_insuf      <= saldo_next_s;
         ocupado          <= ocupado_next_s;
      end
   end

endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda: a vector table for single-transaction
// behaviour plus hand-written sequences for idle timeout and reset aborts.
// Outputs are compared as {libera, produto_out, troco, troco_valido,
// limpa_acumulador, saldo_insuf, ocupado}.
module tb_controle_venda;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] total;
   logic [1:0] produto;
   logic       confirma;
   logic       cancela;
   logic       libera;
   logic [1:0] produto_out;
   logic [3:0] troco;
   logic       troco_valido;
   logic       limpa_acumulador;
   logic       saldo_insuf;
   logic       ocupado;
   logic [10:0] saidas;

   int erros  = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  tot;
      logic [1:0]  prod;
      logic        conf;
      logic        canc;
      logic [10:0] esp;
      string       nome;
   } vetor_t;

   vetor_t tab [30];

   controle_venda dut (
      .clk              (clk),
      .reset            (reset),
      .total            (total),
      .produto          (produto),
      .confirma         (confirma),
      .cancela          (cancela),
      .libera           (libera),
      .produto_out      (produto_out),
      .troco            (troco),
      .troco_valido     (troco_valido),
      .limpa_acumulador (limpa_acumulador),
      .saldo_insuf      (saldo_insuf),
      .ocupado          (ocupado)
   );

   always #5 clk = ~clk;

   assign saidas = {libera, produto_out, troco, troco_valido,
                    limpa_acumulador, saldo_insuf, ocupado};

   function automatic logic [10:0] pk(input logic l, input logic [1:0] po,
                                      input logic [3:0] tr, input logic tv,
                                      input logic lm, input logic si,
                                      input logic oc);
      return {l, po, tr, tv, lm, si, oc};
   endfunction

   function automatic vetor_t mk(input logic r, input logic [3:0] t,
                                 input logic [1:0] p, input logic cf,
                                 input logic cc, input logic [10:0] e,
                                 input string n);
      vetor_t v;
      v.rst = r; v.tot = t; v.prod = p; v.conf = cf; v.canc = cc;
      v.esp = e; v.nome = n;
      return v;
   endfunction

   task automatic aplica(input logic r, input logic [3:0] t, input logic [1:0] p,
                         input logic cf, input logic cc);
      reset = r; total = t; produto = p; confirma = cf; cancela = cc;
   endtask

   task automatic passo();
      @(posedge clk);
      #1;
   endtask

   task automatic confere(input string nome, input logic [10:0] esperado);
      checks++;
      if (saidas !== esperado) begin
         erros++;
         $display("FAIL %s: got %b (lib,prod,troco,tv,limpa,insuf,ocup) expected %b",
                  nome, saidas, esperado);
      end
   endtask

   initial begin
      logic [10:0] zero, ocup, aviso, esp;
      zero  = pk(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      ocup  = pk(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      aviso = pk(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      tab[0]  = mk(1'b1, 4'd0,  2'd0, 1'b0, 1'b0, zero, "reset");
      tab[1]  = mk(1'b0, 4'd4,  2'd1, 1'b1, 1'b0, ocup, "r035_verifica");
      tab[2]  = mk(1'b0, 4'd4,  2'd1, 1'b0, 1'b0, pk(1'b1, 2'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1), "r035_libera");
      tab[3]  = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "r035_ocioso");
      tab[4]  = mk(1'b0, 4'd8,  2'd0, 1'b1, 1'b0, ocup, "r036_verifica");
      tab[5]  = mk(1'b0, 4'd8,  2'd0, 1'b0, 1'b0, pk(1'b1, 2'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1), "r036_libera");
      tab[6]  = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "r036_ocioso");
      tab[7]  = mk(1'b0, 4'd2,  2'd3, 1'b1, 1'b0, ocup, "r037_verifica");
      tab[8]  = mk(1'b0, 4'd2,  2'd3, 1'b0, 1'b0, aviso, "r037_aviso1");
      tab[9]  = mk(1'b0, 4'd2,  2'd3, 1'b1, 1'b0, aviso, "r037_aviso2_confirma");
      tab[10] = mk(1'b0, 4'd2,  2'd3, 1'b0, 1'b0, aviso, "r037_aviso3");
      tab[11] = mk(1'b0, 4'd2,  2'd3, 1'b0, 1'b0, aviso, "r037_aviso4");
      tab[12] = mk(1'b0, 4'd2,  2'd3, 1'b0, 1'b0, zero, "r037_fim_aviso");
      tab[13] = mk(1'b0, 4'd3,  2'd0, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1), "r038_cancela");
      tab[14] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "r038_ocioso");
      tab[15] = mk(1'b0, 4'd5,  2'd0, 1'b1, 1'b1, pk(1'b0, 2'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1), "r038_conf_canc");
      tab[16] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "r038_ocioso2");
      tab[17] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b1, zero, "cancela_sem_credito");
      tab[18] = mk(1'b0, 4'd12, 2'd2, 1'b1, 1'b0, ocup, "clamp_verifica");
      tab[19] = mk(1'b0, 4'd12, 2'd2, 1'b0, 1'b0, pk(1'b1, 2'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1), "clamp_libera");
      tab[20] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "clamp_ocioso");
      tab[21] = mk(1'b0, 4'd15, 2'd0, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1), "clamp_devolve");
      tab[22] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "clamp_ocioso2");
      tab[23] = mk(1'b0, 4'd6,  2'd3, 1'b1, 1'b0, ocup, "exato_verifica");
      tab[24] = mk(1'b0, 4'd6,  2'd3, 1'b0, 1'b0, pk(1'b1, 2'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1), "exato_libera");
      tab[25] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "exato_ocioso");
      tab[26] = mk(1'b0, 4'd1,  2'd0, 1'b1, 1'b0, ocup, "aviso_canc_verifica");
      tab[27] = mk(1'b0, 4'd1,  2'd0, 1'b0, 1'b0, aviso, "aviso_canc_aviso");
      tab[28] = mk(1'b0, 4'd1,  2'd0, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1), "aviso_canc_devolve");
      tab[29] = mk(1'b0, 4'd0,  2'd0, 1'b0, 1'b0, zero, "aviso_canc_ocioso");

      aplica(1'b1, 4'd0, 2'd0, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         aplica(tab[i].rst, tab[i].tot, tab[i].prod, tab[i].conf, tab[i].canc);
         passo();
         confere(tab[i].nome, tab[i].esp);
      end

      // Inactivity refund: credit of 1 held with no requests.
      aplica(1'b1, 4'd0, 2'd0, 1'b0, 1'b0);
      passo();
      confere("inat_reset", zero);
      aplica(1'b0, 4'd1, 2'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         passo();
         esp = (i == 16) ? pk(1'b0, 2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1) : zero;
         confere($sformatf("inat_ciclo_%0d", i), esp);
      end
      aplica(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      passo();
      confere("inat_volta", zero);

      // Credit changes on the 10th idle cycle: count restarts from there.
      for (int i = 1; i <= 25; i++) begin
         aplica(1'b0, (i < 10) ? 4'd1 : 4'd2, 2'd0, 1'b0, 1'b0);
         passo();
         esp = (i == 25) ? pk(1'b0, 2'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1) : zero;
         confere($sformatf("inat_reinicio_%0d", i), esp);
      end
      aplica(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      passo();
      confere("inat_reinicio_volta", zero);

      // Reset while in AVISO.
      aplica(1'b0, 4'd2, 2'd3, 1'b1, 1'b0);
      passo();
      confere("rst_aviso_verifica", ocup);
      aplica(1'b0, 4'd2, 2'd3, 1'b0, 1'b0);
      passo();
      confere("rst_aviso_1", aviso);
      passo();
      confere("rst_aviso_2", aviso);
      aplica(1'b1, 4'd2, 2'd3, 1'b0, 1'b0);
      passo();
      confere("rst_aviso_reset", zero);
      aplica(1'b0, 4'd2, 2'd3, 1'b0, 1'b0);
      passo();
      confere("rst_aviso_pos", zero);

      // Reset where VERIFICA would move to LIBERA: no dispense, no change.
      aplica(1'b0, 4'd4, 2'd1, 1'b1, 1'b0);
      passo();
      confere("rst_verifica_verifica", ocup);
      aplica(1'b1, 4'd4, 2'd1, 1'b0, 1'b0);
      passo();
      confere("rst_verifica_reset", zero);
      aplica(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
      passo();
      confere("rst_verifica_pos", zero);

      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule

// File: doc/controle_venda.md
CONTROLE_VENDA -- requirements
Module: controle_venda

Interface
REQ-001 SHALL have parameter PRECO_0, default 3, price of product 00 in 25-cent units (R$0.75).
REQ-002 SHALL have parameter PRECO_1, default 4, price of product 01 (R$1.00).
REQ-003 SHALL have parameter PRECO_2, default 5, price of product 10 (R$1.25).
REQ-004 SHALL have parameter PRECO_3, default 6, price of product 11 (R$1.50).
REQ-005 SHALL have parameter T_AVISO, default 4, cycles the insufficient-credit warning is held.
REQ-006 SHALL have parameter T_INATIVO, default 16, idle cycles with credit before automatic refund.
REQ-007 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port total  input  4  accumulated credit in 25-cent units (0..8), from the coin accumulator.
REQ-010 SHALL have port produto  input  2  product selection code.
REQ-011 SHALL have port confirma  input  1  purchase request, sampled each edge.
REQ-012 SHALL have port cancela  input  1  refund request, sampled each edge.
REQ-013 SHALL have port libera  output  1  one-cycle dispense pulse.
REQ-014 SHALL have port produto_out  output  2  product being dispensed, valid while libera=1.
REQ-015 SHALL have port troco  output  4  change in 25-cent units, valid while troco_valido=1.
REQ-016 SHALL have port troco_valido  output  1  one-cycle change-return pulse.
REQ-017 SHALL have port limpa_acumulador  output  1  one-cycle pulse clearing the coin accumulator.
REQ-018 SHALL have port saldo_insuf  output  1  insufficient-credit warning.
REQ-019 SHALL have port ocupado  output  1  high in every state except OCIOSO.

Function
REQ-020 SHALL implement states OCIOSO, VERIFICA, LIBERA, AVISO, DEVOLVE; outputs decoded from registered state and registers only (Moore).
REQ-021 SHALL clamp total values above 8 to 8 at every use.
REQ-022 OCIOSO: cancela=1 with total!=0 -> DEVOLVE; else confirma=1 -> latch produto into sel, go VERIFICA; cancela has priority when both are high.
REQ-023 OCIOSO: cancela=1 with total=0 SHALL be ignored (no pulse).
REQ-024 VERIFICA (1 cycle): capture total into cred; cred >= price(sel) -> LIBERA, else -> AVISO.
REQ-025 LIBERA (1 cycle): libera=1, produto_out=sel, troco=cred-price(sel), troco_valido=1, limpa_acumulador=1; then OCIOSO.
REQ-026 libera SHALL be high exactly in the 2nd cycle after the edge sampling confirma; troco_valido SHALL pulse even when change is 0.
REQ-027 AVISO: saldo_insuf=1 for exactly T_AVISO cycles, then OCIOSO with credit kept (no limpa); confirma ignored; cancela -> DEVOLVE.
REQ-028 DEVOLVE (1 cycle): troco=clamped total, troco_valido=1, limpa_acumulador=1; then OCIOSO.
REQ-029 Inactivity counter: counts in OCIOSO while total!=0 and neither confirma nor cancela is high; cleared when total changes, total=0, or state leaves OCIOSO; reaching T_INATIVO -> DEVOLVE.
REQ-030 troco and produto_out SHALL read 0 whenever their valid pulse is low.

Reset
REQ-031 reset=1 at a rising edge SHALL force OCIOSO, clear sel, cred and both counters; all outputs 0 in the following cycle.
REQ-032 Reset mid-operation (any state) SHALL abort without libera, troco_valido or limpa_acumulador pulses.

Structure
REQ-033 Shared package/include SHALL hold state encoding, coin-unit constants (0..8) and default prices, shared with the accumulator.
REQ-034 One sub-module, contador_inatividade (load/clear/count-to-terminal timer), SHALL serve both T_AVISO and T_INATIVO timing.

Verification
REQ-035 total=4, produto=01, confirma pulse -> libera 2 cycles later, produto_out=01, troco=0, troco_valido=1, limpa=1.
REQ-036 total=8, produto=00, confirma -> troco=5, libera=1, then OCIOSO, ocupado=0.
REQ-037 total=2, produto=11, confirma -> saldo_insuf high 4 cycles, no limpa, no libera, return to OCIOSO.
REQ-038 total=3, cancela -> next cycle troco=3, troco_valido=1, limpa=1; confirma+cancela together with total=5 -> refund 5, no libera.
REQ-039 total=1 held, no inputs -> DEVOLVE after 16 idle cycles, troco=1; total change at cycle 10 restarts count.
REQ-040 reset asserted during AVISO -> next cycle all outputs 0, state OCIOSO, no pulses.
